// File: rtl/sklansky_mp_add_ctrl.sv
// Multi-precision add/subtract sequencer that runs one 16-bit Sklansky prefix
// adder over WORDS slices, least significant slice first, with a carry register between slices.
module sklansky_mp_add_ctrl #(
  parameter int W     = 16,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [W*WORDS-1:0] a,
  input  logic [W*WORDS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [W*WORDS-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LG = $clog2(W);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      c_q, c_d;
  logic [WORDS-1:0][W-1:0]   ra_q, ra_d, rb_q, rb_d, result_q, result_d;
  logic                      done_q, done_d;
  logic                      cout_q, cout_d;
  logic                      ovf_q, ovf_d;
  logic [W:0]                add_o;

  // Sklansky parallel-prefix adder: at level l every bit whose index has bit l
  // set merges with the top bit of the lower half of its 2^(l+1) block.
  function automatic logic [W:0] sklansky_add(input logic [W-1:0] x,
                                              input logic [W-1:0] y,
                                              input logic         ci);
    logic [W-1:0] g, p, gg, pp;
    logic [W:0]   c;
    int           j;
    g  = x & y;
    p  = x ^ y;
    gg = g;
    pp = p;
    for (int l = 0; l < LG; l++) begin
      for (int i = 0; i < W; i++) begin
        if (i[l]) begin
          j = ((i >> l) << l) - 1;
          gg[i] = gg[i] | (pp[i] & gg[j[LG-1:0]]);
          pp[i] = pp[i] & pp[j[LG-1:0]];
        end
      end
    end
    c[0] = ci;
    for (int i = 0; i < W; i++) c[i+1] = gg[i] | (pp[i] & ci);
    return {c[W], p ^ c[W-1:0]};
  endfunction

  always_comb begin
    add_o = sklansky_add(ra_q[idx_q], rb_q[idx_q], c_q);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    c_d      = c_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    result_d = result_q;
    done_d   = 1'b0;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d     = a;
          rb_d     = sub ? ~b : b;
          c_d      = sub;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[idx_q] = add_o[W-1:0];
        c_d             = add_o[W];
        idx_d           = idx_q + 1'b1;
        if (idx_q == IW'(WORDS - 1)) begin
          // rb already holds ~b for subtraction, so one overflow rule covers both
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
          cout_d  = add_o[W];
          ovf_d   = (ra_q[WORDS-1][W-1] == rb_q[WORDS-1][W-1]) &&
                    (add_o[W-1] != ra_q[WORDS-1][W-1]);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      result_q <= result_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    ra_q <= ra_d;
    rb_q <= rb_d;
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sklansky_mp_add_ctrl.sv
// Scoreboard bench for sklansky_mp_add_ctrl: stimulus pushes expected results,
// a done-triggered monitor pops and compares them.
module tb_sklansky_mp_add_ctrl;

  localparam int W     = 16;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  typedef struct {
    logic [N-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, cout, overflow;
  logic [N-1:0] result;

  exp_t q[$];
  int   total = 0;
  int   pass  = 0;
  int   ndone = 0;
  int   nexp  = 0;

  sklansky_mp_add_ctrl #(.W(W), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  // Reference: plain modular arithmetic, unsigned compare for carry/borrow,
  // and an (N+1)-bit signed result for overflow.
  function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    exp_t e;
    logic [N:0]        u;
    logic signed [N:0] sf;
    if (!s) begin
      u    = {1'b0, x} + {1'b0, y};
      e.res = u[N-1:0];
      e.co  = u[N];
      sf   = $signed({x[N-1], x}) + $signed({y[N-1], y});
    end else begin
      e.res = x - y;
      e.co  = (x >= y);
      sf   = $signed({x[N-1], x}) - $signed({y[N-1], y});
    end
    e.ov = (sf[N] != sf[N-1]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      ndone++;
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1, expected no pulse");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("cout", N'(cout), N'(e.co));
        chk("overflow", N'(overflow), N'(e.ov));
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the start edge.
  task automatic launch(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    a = x; b = y; sub = s; start = 1'b1;
    q.push_back(model(x, y, s));
    nexp++;
    @(posedge clk); #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    sub = $urandom_range(0, 1);
  endtask

  task automatic wait_done(input int n);
    for (int k = 0; k < n; k++) begin
      chk("busy_run", N'(busy), N'(1));
      chk("done_early", N'(done), N'(0));
      @(posedge clk); #1;
    end
    chk("done_pulse", N'(done), N'(1));
    chk("busy_at_done", N'(busy), N'(0));
  endtask

  task automatic op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    launch(x, y, s);
    wait_done(WORDS);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_done", N'(done), N'(0));
    chk("rst_result", result, '0);
    chk("rst_cout", N'(cout), N'(0));
    chk("rst_overflow", N'(overflow), N'(0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs();

    op(64'd15, 64'd8, 1'b0);
    op(64'd269, 64'd4170, 1'b0);
    op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0);
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    op(64'd0, 64'd1, 1'b1);
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    op(64'h8000_0000_0000_0000, 64'd1, 1'b1);

    // Start while busy is ignored; the first operation still completes alone
    launch(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0);
    @(posedge clk); #1;
    a = 64'hDEAD_BEEF_0000_0001; b = 64'h1; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(WORDS - 2);

    // Back-to-back: start issued in the done cycle
    op(64'hAAAA_5555_AAAA_5555, 64'h5555_AAAA_5555_AAAB, 1'b0);
    op(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1);

    // Give cout/overflow a non-zero value, then abort mid-run with reset
    op(64'h8000_0000_0000_0000, 64'd1, 1'b1);
    launch(64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    void'(q.pop_back());
    nexp--;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_outputs();
    repeat (6) @(posedge clk);
    #1;
    op(64'd100, 64'd58, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [N-1:0] x, y;
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: y = ~x;
        1: x = {1'b0, {(N-1){1'b1}}};
        default: ;
      endcase
      op(x, y, 1'b0 ^ $urandom_range(0, 1));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", N'(ndone), N'(nexp));
    chk("queue_empty", N'(q.size()), '0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
